mem_stage: RTL and testbench

- MEM pipeline stage of the 5-stage RV32I core; sits directly downstream of the EX/MEM latch and consumes the EX stage's op, mem_addr, rd_data and rd_addr.
- Loads and stores are serialised into byte transactions on the 8-bit memory-controller port, with a stall back to the pipeline. All other ops pass through to MEM/WB with zero latency.

---
 rtl/mem_stage_pkg.sv | 56 +++++
 rtl/mem_stage_if.sv | 34 +++
 rtl/mem_stage_load_ext.sv | 23 ++
 rtl/mem_stage.sv | 133 +++++++++++++
 tb/tb_mem_stage.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: op encodings, constants, FSM states
// and the load/store decode helpers.
package mem_stage_pkg;

  localparam int OP_LEN   = 6;
  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;

  localparam logic [OP_LEN-1:0] OP_NOP  = 6'h00;
  localparam logic [OP_LEN-1:0] OP_ADDI = 6'h01;
  localparam logic [OP_LEN-1:0] OP_ADD  = 6'h02;
  localparam logic [OP_LEN-1:0] OP_BEQ  = 6'h08;
  localparam logic [OP_LEN-1:0] OP_JAL  = 6'h0C;
  localparam logic [OP_LEN-1:0] OP_JALR = 6'h0D;
  localparam logic [OP_LEN-1:0] OP_LB   = 6'h10;
  localparam logic [OP_LEN-1:0] OP_LH   = 6'h11;
  localparam logic [OP_LEN-1:0] OP_LW   = 6'h12;
  localparam logic [OP_LEN-1:0] OP_LBU  = 6'h14;
  localparam logic [OP_LEN-1:0] OP_LHU  = 6'h15;
  localparam logic [OP_LEN-1:0] OP_SB   = 6'h18;
  localparam logic [OP_LEN-1:0] OP_SH   = 6'h19;
  localparam logic [OP_LEN-1:0] OP_SW   = 6'h1A;

  localparam logic [DATA_LEN-1:0] ZERO_WORD   = '0;
  localparam logic [4:0]          RegAddrZero = 5'd0;
  localparam logic                True        = 1'b1;
  localparam logic                False       = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  function automatic logic is_load(input logic [OP_LEN-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [OP_LEN-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_mem(input logic [OP_LEN-1:0] op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic [2:0] byte_count(input logic [OP_LEN-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide memory-controller port between the MEM stage (master) and the
// memory controller (slave).
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_LEN
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_done;

  modport master (
    output mem_req,
    output mem_we,
    output mem_a,
    output mem_wdata,
    input  mem_rdata,
    input  mem_done
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_a,
    input  mem_wdata,
    output mem_rdata,
    output mem_done
  );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Sign/zero extension of an assembled little-endian load word according to
// the load op width and signedness.
module mem_stage_load_ext
  import mem_stage_pkg::*;
(
  input  logic [OP_LEN-1:0]   op_i,
  input  logic [DATA_LEN-1:0] word_i,
  output logic [DATA_LEN-1:0] data_o
);

  always_comb begin
    data_o = ZERO_WORD;
    case (op_i)
      OP_LB:   data_o = {{24{word_i[7]}}, word_i[7:0]};
      OP_LBU:  data_o = {24'h000000, word_i[7:0]};
      OP_LH:   data_o = {{16{word_i[15]}}, word_i[15:0]};
      OP_LHU:  data_o = {16'h0000, word_i[15:0]};
      OP_LW:   data_o = word_i;
      default: data_o = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: serialises loads/stores into byte transactions on the
// memory-controller port and stalls the pipeline; other ops pass straight through.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int OP_W   = OP_LEN,
  parameter int ADDR_W = ADDR_LEN,
  parameter int DATA_W = DATA_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              mem_stall,
  mem_stage_if.master       mem_bus
);

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        rd_q, rd_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] ext_data;

  // data_q holds the store data, or the load word as bytes arrive.
  mem_stage_load_ext u_load_ext (
    .op_i   (op_q),
    .word_i (data_q),
    .data_o (ext_data)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_d      = rd_q;
    rd_data_o = ZERO_WORD;
    rd_addr_o = RegAddrZero;
    mem_stall = False;

    unique case (state_q)
      IDLE: begin
        if (is_mem(op_i)) begin
          mem_stall = True;
          op_d      = op_i;
          addr_d    = mem_addr_i;
          data_d    = rd_data_i;
          rd_d      = rd_addr_i;
          k_d       = 2'd0;
          state_d   = ACCESS;
        end else begin
          rd_data_o = rd_data_i;
          rd_addr_o = rd_addr_i;
        end
      end
      ACCESS: begin
        mem_stall = True;
        if (mem_bus.mem_done) begin
          if (is_load(op_q)) begin
            data_d[{k_q, 3'b000} +: 8] = mem_bus.mem_rdata;
          end
          k_d = k_q + 2'd1;
          if ({1'b0, k_q} == byte_count(op_q) - 3'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (is_load(op_q)) begin
          rd_data_o = ext_data;
          rd_addr_o = rd_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rst) begin
      rd_data_o = ZERO_WORD;
      rd_addr_o = RegAddrZero;
      mem_stall = False;
    end

    // Bus outputs are registered from the next-state view so they stay stable during waits.
    mem_req_d   = (state_d == ACCESS);
    mem_we_d    = mem_req_d && is_store(op_d);
    mem_a_d     = mem_req_d ? addr_d + ADDR_W'(k_d) : '0;
    mem_wdata_d = mem_we_d ? data_d[{k_d, 3'b000} +: 8] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      op_q        <= OP_NOP;
      addr_q      <= '0;
      data_q      <= ZERO_WORD;
      rd_q        <= RegAddrZero;
      mem_req_q   <= False;
      mem_we_q    <= False;
      mem_a_q     <= '0;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_a_q     <= mem_a_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_bus.mem_req   = mem_req_q;
  assign mem_bus.mem_we    = mem_we_q;
  assign mem_bus.mem_a     = mem_a_q;
  assign mem_bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a byte-addressed memory model and a
// per-instruction timeline model drive expectations checked every cycle.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op_i;
  logic [31:0] rd_data_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] mem_addr_i;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        mem_stall;

  mem_stage_if bus ();

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .op_i       (op_i),
    .rd_data_i  (rd_data_i),
    .rd_addr_i  (rd_addr_i),
    .mem_addr_i (mem_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_addr_o  (rd_addr_o),
    .mem_stall  (mem_stall),
    .mem_bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp     = 0;
  int n_fail    = 0;
  int stall_cnt = 0;

  logic        exp_on     = 1'b0;
  logic        exp_stall  = 1'b0;
  logic [31:0] exp_rd_data = 32'h0;
  logic [4:0]  exp_rd_addr = 5'd0;
  logic        exp_mem_on = 1'b0;
  logic        exp_req    = 1'b0;
  logic        exp_bus_on = 1'b0;
  logic [31:0] exp_a      = 32'h0;
  logic        exp_we     = 1'b0;
  logic        exp_wd_on  = 1'b0;
  logic [7:0]  exp_wdata  = 8'h00;

  logic [7:0] mem_model [logic [31:0]];
  int         wait_tab [4];

  logic [5:0] op_pool [13] = '{OP_NOP, OP_ADDI, OP_ADD, OP_BEQ, OP_JAL, OP_LB, OP_LH,
                               OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      if (mem_stall === 1'b1) stall_cnt++;
      checkOutput("mem_stall", 32'(mem_stall), 32'(exp_stall));
      checkOutput("rd_data_o", rd_data_o, exp_rd_data);
      checkOutput("rd_addr_o", 32'(rd_addr_o), 32'(exp_rd_addr));
      if (exp_mem_on) checkOutput("mem_req", 32'(bus.mem_req), 32'(exp_req));
      if (exp_bus_on) begin
        checkOutput("mem_a", bus.mem_a, exp_a);
        checkOutput("mem_we", 32'(bus.mem_we), 32'(exp_we));
      end
      if (exp_wd_on) checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
    end
  end

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic expectPipe(input logic stall, input logic [31:0] d, input logic [4:0] a);
    exp_on      = 1'b1;
    exp_stall   = stall;
    exp_rd_data = d;
    exp_rd_addr = a;
  endtask

  task automatic expectBus(input logic chk_req, input logic req, input logic chk_bus,
                           input logic [31:0] a, input logic we, input logic chk_wd,
                           input logic [7:0] wd);
    exp_mem_on = chk_req;
    exp_req    = req;
    exp_bus_on = chk_bus;
    exp_a      = a;
    exp_we     = we;
    exp_wd_on  = chk_wd;
    exp_wdata  = wd;
  endtask

  function automatic int nbytes(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    if (op == OP_LW || op == OP_SW) return 4;
    return 0;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int b);
    return d[8*b +: 8];
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] w);
    int v;
    if (op == OP_LB) begin
      v = int'(w[7:0]);
      if (v >= 128) v = v - 256;
      return 32'(v);
    end
    if (op == OP_LH) begin
      v = int'(w[15:0]);
      if (v >= 32768) v = v - 65536;
      return 32'(v);
    end
    if (op == OP_LBU) return w & 32'h0000_00FF;
    if (op == OP_LHU) return w & 32'h0000_FFFF;
    return w;
  endfunction

  task automatic setWaits(input int w0, input int w1, input int w2, input int w3);
    wait_tab[0] = w0;
    wait_tab[1] = w1;
    wait_tab[2] = w2;
    wait_tab[3] = w3;
  endtask

  // Drives one instruction through to the cycle after it leaves MEM.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                               input logic [31:0] data, input logic [4:0] rd,
                               output logic [31:0] model_res);
    int          n;
    logic        is_st;
    logic [31:0] word;
    logic [31:0] ba;
    logic [7:0]  bt;
    n          = nbytes(op);
    is_st      = (op == OP_SB || op == OP_SH || op == OP_SW);
    op_i       = op;
    mem_addr_i = addr;
    rd_data_i  = data;
    rd_addr_i  = rd;
    bus.mem_done  = 1'($urandom_range(0, 1));
    bus.mem_rdata = 8'($urandom);
    if (n == 0) begin
      expectPipe(1'b0, data, rd);
      expectBus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      model_res = data;
      nextCycle;
      return;
    end
    expectPipe(1'b1, 32'h0, 5'd0);
    expectBus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    nextCycle;
    word = 32'h0;
    for (int b = 0; b < n; b++) begin
      ba = addr + 32'(b);
      for (int w = 0; w <= wait_tab[b]; w++) begin
        expectPipe(1'b1, 32'h0, 5'd0);
        expectBus(1'b1, 1'b1, 1'b1, ba, is_st, is_st, is_st ? byte_of(data, b) : 8'h00);
        if (w == wait_tab[b]) begin
          bus.mem_done = 1'b1;
          if (is_st) begin
            mem_model[ba] = byte_of(data, b);
            bus.mem_rdata = 8'($urandom);
          end else begin
            bt = mem_rd(ba);
            bus.mem_rdata = bt;
            word = word | (32'(bt) << (8 * b));
          end
        end else begin
          bus.mem_done  = 1'b0;
          bus.mem_rdata = 8'($urandom);
        end
        nextCycle;
      end
    end
    model_res = is_st ? 32'h0 : extend(op, word);
    expectPipe(1'b0, model_res, is_st ? 5'd0 : rd);
    expectBus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    bus.mem_done = 1'($urandom_range(0, 1));
    nextCycle;
  endtask

  task automatic resetAbort;
    op_i = OP_LW; mem_addr_i = 32'h300; rd_addr_i = 5'd4; rd_data_i = 32'h0;
    bus.mem_done = 1'b0;
    expectPipe(1'b1, 32'h0, 5'd0);
    expectBus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    nextCycle;
    expectBus(1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 8'h00);
    bus.mem_done = 1'b1; bus.mem_rdata = 8'hAA;
    nextCycle;
    expectBus(1'b1, 1'b1, 1'b1, 32'h301, 1'b0, 1'b0, 8'h00);
    bus.mem_done = 1'b0;
    nextCycle;
    rst = 1'b0;
    expectPipe(1'b0, 32'h0, 5'd0);
    expectBus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    nextCycle;
    rst = 1'b1; op_i = OP_ADDI; rd_data_i = 32'h77; rd_addr_i = 5'd6;
    expectPipe(1'b0, 32'h77, 5'd6);
    expectBus(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 8'h00);
    nextCycle;
    for (int i = 0; i < 3; i++) begin
      op_i = OP_NOP; rd_data_i = 32'h33 + 32'(i); rd_addr_i = 5'd1;
      bus.mem_done = 1'b1;
      expectPipe(1'b0, 32'h33 + 32'(i), 5'd1);
      expectBus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      nextCycle;
    end
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] addr;
    logic [5:0]  op;
    rst = 1'b0; op_i = OP_NOP; rd_data_i = 32'h0; rd_addr_i = 5'd0; mem_addr_i = 32'h0;
    bus.mem_done = 1'b0; bus.mem_rdata = 8'h00;
    nextCycle;

    op_i = OP_ADDI; rd_data_i = 32'hDEAD_BEEF; rd_addr_i = 5'd7;
    expectPipe(1'b0, 32'h0, 5'd0);
    expectBus(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 8'h00);
    nextCycle;
    op_i = OP_LW;
    nextCycle;
    rst = 1'b1; op_i = OP_NOP; rd_data_i = 32'h11; rd_addr_i = 5'd2;
    expectPipe(1'b0, 32'h11, 5'd2);
    nextCycle;

    setWaits(0, 0, 0, 0);
    applyStimulus(OP_ADDI, 32'h0, 32'h0000_002A, 5'd5, res);
    checkOutput("pin_addi", res, 32'h0000_002A);

    mem_model[32'h100] = 8'h78; mem_model[32'h101] = 8'h56;
    mem_model[32'h102] = 8'h34; mem_model[32'h103] = 8'h12;
    stall_cnt = 0;
    applyStimulus(OP_LW, 32'h100, 32'h0, 5'd10, res);
    checkOutput("pin_lw", res, 32'h1234_5678);
    checkOutput("lw_stall_cycles", 32'(stall_cnt), 32'd5);

    mem_model[32'h40] = 8'h80;
    applyStimulus(OP_LB, 32'h40, 32'h0, 5'd11, res);
    checkOutput("pin_lb", res, 32'hFFFF_FF80);
    applyStimulus(OP_LBU, 32'h40, 32'h0, 5'd12, res);
    checkOutput("pin_lbu", res, 32'h0000_0080);
    mem_model[32'h50] = 8'h00; mem_model[32'h51] = 8'h90;
    applyStimulus(OP_LH, 32'h50, 32'h0, 5'd13, res);
    checkOutput("pin_lh", res, 32'hFFFF_9000);

    applyStimulus(OP_SH, 32'h202, 32'hABCD_1234, 5'd0, res);
    checkOutput("pin_sh_lo", 32'(mem_model[32'h202]), 32'h34);
    checkOutput("pin_sh_hi", 32'(mem_model[32'h203]), 32'h12);

    setWaits(2, 2, 2, 2);
    stall_cnt = 0;
    applyStimulus(OP_SW, 32'hFFFF_FFFE, 32'hCAFE_F00D, 5'd9, res);
    checkOutput("sw_stall_cycles", 32'(stall_cnt), 32'd13);
    checkOutput("pin_sw_wrap", 32'(mem_model[32'h1]), 32'hCA);
    setWaits(1, 0, 2, 0);
    applyStimulus(OP_LW, 32'hFFFF_FFFE, 32'h0, 5'd14, res);
    checkOutput("pin_lw_wrap", res, 32'hCAFE_F00D);

    setWaits(0, 1, 0, 1);
    applyStimulus(OP_LW, 32'h100, 32'h0, 5'd0, res);

    resetAbort();

    for (int i = 0; i < 200; i++) begin
      op   = op_pool[$urandom_range(0, 12)];
      addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                         : 32'h1000 + 32'($urandom_range(0, 31));
      setWaits(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      applyStimulus(op, addr, $urandom, 5'($urandom), res);
    end

    exp_on = 1'b0;
    nextCycle;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
